// File: rtl/skin_pkg.sv
// Shared constants, output-mode type and saturating helper for the skin scorer.
package skin_pkg;

  localparam int unsigned DEF_CR_CENTER  = 155;
  localparam int unsigned DEF_CB_CENTER  = 110;
  localparam int unsigned DEF_Y_MIN      = 40;
  localparam int unsigned DEF_Y_MAX      = 235;
  localparam int unsigned DEF_GAIN_SHIFT = 2;

  typedef enum logic {
    SCORE = 1'b0,
    MASK  = 1'b1
  } mode_e;

  // a - b, clamped at zero instead of wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/skin_score_lane.sv
// One lane of the skin scorer: chroma distance, penalty/score, threshold/mask.
// Each stage register loads on its own enable, supplied by the top-level handshake.
module skin_score_lane
  import skin_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned CR_CENTER  = DEF_CR_CENTER,
  parameter int unsigned CB_CENTER  = DEF_CB_CENTER,
  parameter int unsigned Y_MIN      = DEF_Y_MIN,
  parameter int unsigned Y_MAX      = DEF_Y_MAX,
  parameter int unsigned GAIN_SHIFT = DEF_GAIN_SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en1,
  input  logic               i_en2,
  input  logic               i_en3,
  input  logic [DATA_W-1:0]  i_y,
  input  logic [DATA_W-1:0]  i_cb,
  input  logic [DATA_W-1:0]  i_cr,
  input  mode_e              i_mode,
  input  logic [SCORE_W-1:0] i_thresh,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_skin
);

  localparam int unsigned D_W = DATA_W + 1;
  localparam int unsigned P_W = D_W + GAIN_SHIFT;
  localparam logic [DATA_W-1:0] CR_C = DATA_W'(CR_CENTER);
  localparam logic [DATA_W-1:0] CB_C = DATA_W'(CB_CENTER);
  localparam logic [DATA_W-1:0] Y_LO = DATA_W'(Y_MIN);
  localparam logic [DATA_W-1:0] Y_HI = DATA_W'(Y_MAX);
  localparam logic [31:0]       SMAX = (32'd1 << SCORE_W) - 32'd1;

  logic [DATA_W-1:0]  w_dcr;
  logic [DATA_W-1:0]  w_dcb;
  logic [D_W-1:0]     w_d;
  logic               w_ygate;
  logic [P_W-1:0]     w_pen;
  logic [SCORE_W-1:0] w_score;
  logic               w_skin;

  logic [D_W-1:0]     r_d;
  logic               r_ygate;
  logic [SCORE_W-1:0] r_score;

  // Stage-1 and stage-2 combinational math; S3 threshold compare.
  always_comb begin
    w_dcr   = (i_cr >= CR_C) ? (i_cr - CR_C) : (CR_C - i_cr);
    w_dcb   = (i_cb >= CB_C) ? (i_cb - CB_C) : (CB_C - i_cb);
    w_d     = {1'b0, w_dcr} + {1'b0, w_dcb};
    w_ygate = (i_y >= Y_LO) && (i_y <= Y_HI);
    w_pen   = P_W'(r_d) << GAIN_SHIFT;
    // Subtracting the unclamped penalty with a zero floor equals max - sat(pen).
    w_score = r_ygate ? SCORE_W'(sat_sub(SMAX, 32'(w_pen))) : '0;
    w_skin  = (r_score >= i_thresh);
  end

  // Three pipeline registers, each gated by its stage's advance enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d     <= '0;
      r_ygate <= 1'b0;
      r_score <= '0;
      o_score <= '0;
      o_skin  <= 1'b0;
    end else begin
      if (i_en1) begin
        r_d     <= w_d;
        r_ygate <= w_ygate;
      end
      if (i_en2) begin
        r_score <= w_score;
      end
      if (i_en3) begin
        o_score <= (i_mode == MASK) ? {SCORE_W{w_skin}} : r_score;
        o_skin  <= w_skin;
      end
    end
  end

endmodule

// File: rtl/skin_score_stream.sv
// Multi-lane skin-tone scorer with valid/ready pipeline, frame markers and
// per-frame skin-pixel count.
module skin_score_stream
  import skin_pkg::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned CR_CENTER  = DEF_CR_CENTER,
  parameter int unsigned CB_CENTER  = DEF_CB_CENTER,
  parameter int unsigned Y_MIN      = DEF_Y_MIN,
  parameter int unsigned Y_MAX      = DEF_Y_MAX,
  parameter int unsigned GAIN_SHIFT = DEF_GAIN_SHIFT,
  parameter int unsigned CNT_W      = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SCORE_W-1:0]       thresh,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic                     sof_in,
  input  logic                     eof_in,
  input  logic [LANES*DATA_W-1:0]  Y,
  input  logic [LANES*DATA_W-1:0]  Cb,
  input  logic [LANES*DATA_W-1:0]  Cr,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic                     sof_out,
  output logic                     eof_out,
  output logic [LANES*SCORE_W-1:0] skinScore,
  output logic [CNT_W-1:0]         frame_count,
  output logic                     count_valid
);

  localparam int unsigned POP_W = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic w_en1, w_en2, w_en3, w_acc, w_hs;
  logic [LANES-1:0]  w_skin;
  logic [POP_W-1:0]  w_pop;
  logic [CNT_W-1:0]  w_base;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_sat;
  mode_e             w_mode_in;

  logic r_v1, r_v2, r_v3;
  logic r_sof1, r_sof2, r_sof3;
  logic r_eof1, r_eof2, r_eof3;
  mode_e              r_mode, r_mode1, r_mode2;
  logic [SCORE_W-1:0] r_thresh, r_thresh1, r_thresh2;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_fc;
  logic               r_cv;

  // Stage enables: a stage loads when it is empty or its contents move on.
  always_comb begin
    w_en3     = !r_v3 || ready_out;
    w_en2     = !r_v2 || w_en3;
    w_en1     = !r_v1 || w_en2;
    ready_in  = w_en1 && !rst;
    w_acc     = valid_in && ready_in;
    w_hs      = r_v3 && ready_out;
    w_mode_in = mode_e'(mode);
  end

  // Popcount of the S3 skin flags and saturating frame accumulation.
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_pop = w_pop + POP_W'(w_skin[i]);
    end
    w_base = r_sof3 ? '0 : r_cnt;
    w_sum  = {1'b0, w_base} + SUM_W'(w_pop);
    w_sat  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  // mode/thresh are latched per frame at sof, and a copy rides with every beat
  // so a following frame's sof cannot retune beats of the previous frame still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;  r_v2 <= 1'b0;  r_v3 <= 1'b0;
      r_sof1 <= 1'b0; r_sof2 <= 1'b0; r_sof3 <= 1'b0;
      r_eof1 <= 1'b0; r_eof2 <= 1'b0; r_eof3 <= 1'b0;
      r_mode <= SCORE; r_mode1 <= SCORE; r_mode2 <= SCORE;
      r_thresh <= '0; r_thresh1 <= '0; r_thresh2 <= '0;
    end else begin
      if (w_acc && sof_in) begin
        r_mode   <= w_mode_in;
        r_thresh <= thresh;
      end
      if (w_en1) begin
        r_v1      <= w_acc;
        r_sof1    <= w_acc && sof_in;
        r_eof1    <= w_acc && eof_in;
        r_mode1   <= sof_in ? w_mode_in : r_mode;
        r_thresh1 <= sof_in ? thresh : r_thresh;
      end
      if (w_en2) begin
        r_v2      <= r_v1;
        r_sof2    <= r_sof1;
        r_eof2    <= r_eof1;
        r_mode2   <= r_mode1;
        r_thresh2 <= r_thresh1;
      end
      if (w_en3) begin
        r_v3   <= r_v2;
        r_sof3 <= r_sof2;
        r_eof3 <= r_eof2;
      end
    end
  end

  // Frame counter: updated on each output handshake, published on eof.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_fc  <= '0;
      r_cv  <= 1'b0;
    end else begin
      r_cv <= 1'b0;
      if (w_hs) begin
        if (r_eof3) begin
          r_fc  <= w_sat;
          r_cv  <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_cnt <= w_sat;
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    skin_score_lane #(
      .DATA_W    (DATA_W),
      .SCORE_W   (SCORE_W),
      .CR_CENTER (CR_CENTER),
      .CB_CENTER (CB_CENTER),
      .Y_MIN     (Y_MIN),
      .Y_MAX     (Y_MAX),
      .GAIN_SHIFT(GAIN_SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en1   (w_en1),
      .i_en2   (w_en2),
      .i_en3   (w_en3),
      .i_y     (Y[g*DATA_W +: DATA_W]),
      .i_cb    (Cb[g*DATA_W +: DATA_W]),
      .i_cr    (Cr[g*DATA_W +: DATA_W]),
      .i_mode  (r_mode2),
      .i_thresh(r_thresh2),
      .o_score (skinScore[g*SCORE_W +: SCORE_W]),
      .o_skin  (w_skin[g])
    );
  end

  assign valid_out   = r_v3;
  assign sof_out     = r_sof3;
  assign eof_out     = r_eof3;
  assign frame_count = r_fc;
  assign count_valid = r_cv;

endmodule

// File: tb/tb_skin_score_stream.sv
// Directed self-checking bench for skin_score_stream (LANES=2, 8-bit data/score).
module tb_skin_score_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [7:0]  thresh = '0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic        sof_in = 1'b0;
  logic        eof_in = 1'b0;
  logic [15:0] Y = '0, Cb = '0, Cr = '0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic        sof_out, eof_out;
  logic [15:0] skinScore;
  logic [23:0] frame_count;
  logic        count_valid;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] b_y[8], b_cb[8], b_cr[8];
  logic        b_sof[8], b_eof[8], b_mode[8];
  logic [7:0]  b_th[8];
  logic [15:0] out_sc[8];
  logic [23:0] fc_q[4];
  int          cv_cnt;
  int          n_out_g;

  skin_score_stream dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .thresh     (thresh),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .sof_in     (sof_in),
    .eof_in     (eof_in),
    .Y          (Y),
    .Cb         (Cb),
    .Cr         (Cr),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .sof_out    (sof_out),
    .eof_out    (eof_out),
    .skinScore  (skinScore),
    .frame_count(frame_count),
    .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setb(input int i, input logic [7:0] y0, cb0, cr0, y1, cb1, cr1,
                      input logic sof, eof, m, input logic [7:0] th);
    b_y[i] = {y1, y0};  b_cb[i] = {cb1, cb0};  b_cr[i] = {cr1, cr0};
    b_sof[i] = sof; b_eof[i] = eof; b_mode[i] = m; b_th[i] = th;
  endtask

  task automatic drive(input int i);
    Y = b_y[i]; Cb = b_cb[i]; Cr = b_cr[i];
    sof_in = b_sof[i]; eof_in = b_eof[i]; mode = b_mode[i]; thresh = b_th[i];
    valid_in = 1'b1;
  endtask

  // Streams n stored beats; ready_out is held low for the first 'stall' cycles.
  task automatic run_stream(input int n, input int stall);
    int n_acc;
    int n_out;
    logic hs;
    n_acc = 0; n_out = 0; cv_cnt = 0;
    for (int k = 0; k < stall + n + 10; k++) begin
      if (stall > 0 && k == stall) begin
        check("stall_accepted", 32'(n_acc), 32'd3);
        check("stall_ready_in", {31'd0, ready_in}, 32'd0);
      end
      ready_out = (k >= stall);
      if (n_acc < n) drive(n_acc);
      else begin
        valid_in = 1'b0; sof_in = 1'b0; eof_in = 1'b0;
      end
      #1;
      hs = valid_in & ready_in;
      if (valid_out && ready_out) begin
        if (n_out < 8) out_sc[n_out] = skinScore;
        n_out++;
      end
      if (count_valid) begin
        if (cv_cnt < 4) fc_q[cv_cnt] = frame_count;
        cv_cnt++;
      end
      tick();
      if (hs) n_acc++;
    end
    valid_in = 1'b0; sof_in = 1'b0; eof_in = 1'b0; ready_out = 1'b1;
    n_out_g = n_out;
  endtask

  initial begin
    int seen;
    // Reset state
    tick(); tick();
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_ready_in", {31'd0, ready_in}, 32'd0);
    check("rst_score", {16'd0, skinScore}, 32'd0);
    check("rst_cv", {31'd0, count_valid}, 32'd0);
    check("rst_fc", {8'd0, frame_count}, 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {31'd0, ready_in}, 32'd1);

    // Latency: lane0 ideal skin pixel, lane1 Y above range
    Y = {8'd250, 8'd90}; Cb = {8'd250, 8'd110}; Cr = {8'd250, 8'd155};
    mode = 1'b0; thresh = 8'd128; sof_in = 1'b1; eof_in = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; sof_in = 1'b0; eof_in = 1'b0;
    tick();
    check("lat_early", {31'd0, valid_out}, 32'd0);
    tick();
    check("lat_valid", {31'd0, valid_out}, 32'd1);
    check("lat_score", {16'd0, skinScore}, 32'h00FF);
    check("lat_sof", {31'd0, sof_out}, 32'd1);
    check("lat_eof", {31'd0, eof_out}, 32'd1);
    tick();
    check("lat_cv", {31'd0, count_valid}, 32'd1);
    check("lat_fc", {8'd0, frame_count}, 32'd1);
    tick();
    check("cv_one_cycle", {31'd0, count_valid}, 32'd0);

    // Saturated penalty on lane0, d=5 pixel on lane1, graded mode
    setb(0, 8'd100, 8'd0, 8'd250, 8'd100, 8'd110, 8'd160, 1'b1, 1'b1, 1'b0, 8'd128);
    run_stream(1, 0);
    check("sat_and_graded", {16'd0, out_sc[0]}, 32'hEB00);
    check("sat_fc", {8'd0, fc_q[0]}, 32'd1);

    // Mask mode, thresh 200 -> both lanes all-ones
    setb(0, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b1, 1'b1, 1'b1, 8'd200);
    run_stream(1, 0);
    check("mask_200", {16'd0, out_sc[0]}, 32'hFFFF);
    check("mask_200_fc", {8'd0, fc_q[0]}, 32'd2);

    // Mask mode, thresh 240 -> zero
    setb(0, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b1, 1'b1, 1'b1, 8'd240);
    run_stream(1, 0);
    check("mask_240", {16'd0, out_sc[0]}, 32'h0000);
    check("mask_240_fc", {8'd0, fc_q[0]}, 32'd0);
    check("mask_240_cv", 32'(cv_cnt), 32'd1);

    // Six beats under a 5-cycle output stall; lane0 d=i, lane1 d=i+6
    for (int i = 0; i < 6; i++)
      setb(i, 8'd100, 8'd110, 8'(155 + i), 8'd100, 8'(116 + i), 8'd155,
           (i == 0), (i == 5), 1'b0, 8'd0);
    run_stream(6, 5);
    check("stall_n_out", 32'(n_out_g), 32'd6);
    for (int i = 0; i < 6; i++)
      check("stall_order", {16'd0, out_sc[i]}, 32'(((231 - 4 * i) << 8) | (255 - 4 * i)));
    check("stall_fc", {8'd0, fc_q[0]}, 32'd12);

    // 4-beat frame with 5 skin lanes (mid-frame mode/thresh change ignored), then 1-beat frame
    setb(0, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b1, 1'b0, 1'b0, 8'd128);
    setb(1, 8'd100, 8'd110, 8'd160, 8'd20,  8'd110, 8'd155, 1'b0, 1'b0, 1'b1, 8'd250);
    setb(2, 8'd20,  8'd110, 8'd155, 8'd100, 8'd110, 8'd160, 1'b0, 1'b0, 1'b1, 8'd250);
    setb(3, 8'd100, 8'd110, 8'd160, 8'd20,  8'd110, 8'd155, 1'b0, 1'b1, 1'b1, 8'd250);
    setb(4, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b1, 1'b1, 1'b0, 8'd128);
    run_stream(5, 0);
    check("frame_cv_count", 32'(cv_cnt), 32'd2);
    check("frame4_fc", {8'd0, fc_q[0]}, 32'd5);
    check("frame1_fc", {8'd0, fc_q[1]}, 32'd2);
    check("midframe_mode", {16'd0, out_sc[2]}, 32'hEB00);
    check("midframe_b3", {16'd0, out_sc[3]}, 32'h00EB);

    // Reset mid-frame drops beats in flight
    setb(0, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b1, 1'b0, 1'b0, 8'd128);
    setb(1, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b0, 1'b0, 1'b0, 8'd128);
    drive(0); tick();
    drive(1); tick();
    valid_in = 1'b0; sof_in = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready_in", {31'd0, ready_in}, 32'd0);
    tick();
    rst = 1'b0;
    check("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (valid_out || count_valid) seen++;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    setb(0, 8'd100, 8'd110, 8'd160, 8'd100, 8'd110, 8'd160, 1'b1, 1'b0, 1'b0, 8'd128);
    setb(1, 8'd100, 8'd110, 8'd160, 8'd20,  8'd110, 8'd155, 1'b0, 1'b1, 1'b0, 8'd128);
    run_stream(2, 0);
    check("postrst_n_out", 32'(n_out_g), 32'd2);
    check("postrst_cv", 32'(cv_cnt), 32'd1);
    check("postrst_fc", {8'd0, fc_q[0]}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
